// File: rtl/vga_pkg.sv
// Shared VGA constants: 800x600@72 timing set, framebuffer geometry and the
// 12-bit colour field layout used by the scan-out path.
package vga_pkg;

   localparam int H_VIS_DEF  = 800;
   localparam int H_FP_DEF   = 56;
   localparam int H_SYNC_DEF = 120;
   localparam int H_BP_DEF   = 64;
   localparam int V_VIS_DEF  = 600;
   localparam int V_FP_DEF   = 37;
   localparam int V_SYNC_DEF = 6;
   localparam int V_BP_DEF   = 23;

   localparam int SCALE_SH_DEF = 2;
   localparam int FB_W_DEF     = 200;
   localparam int RD_LAT_DEF   = 1;

   localparam int CNT_W  = 11;
   localparam int ADDR_W = 15;

   // Framebuffer pixel layout {R, G, B}, four bits each
   localparam int R_HI = 11;
   localparam int R_LO = 8;
   localparam int G_HI = 7;
   localparam int G_LO = 4;
   localparam int B_HI = 3;
   localparam int B_LO = 0;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic fs;
   } sync_t;

endpackage

// File: rtl/vga_timing.sv
// Free-running horizontal/vertical scan counters and raw sync/visible decode.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_VIS  = H_VIS_DEF,
   parameter int H_FP   = H_FP_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP   = H_BP_DEF,
   parameter int V_VIS  = V_VIS_DEF,
   parameter int V_FP   = V_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP   = V_BP_DEF
)(
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] h_cnt,
   output logic [10:0] v_cnt,
   output logic        de,
   output logic        hs,
   output logic        vs,
   output logic        frame_first
);

   localparam logic [10:0] H_MAX      = 11'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] V_MAX      = 11'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] HS_START   = 11'(H_VIS + H_FP);
   localparam logic [10:0] HS_END     = 11'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_START   = 11'(V_VIS + V_FP);
   localparam logic [10:0] VS_END     = 11'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [10:0] H_VIS_LIM  = 11'(H_VIS);
   localparam logic [10:0] V_VIS_LIM  = 11'(V_VIS);

   // The vertical counter only advances as the horizontal one wraps
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_MAX) begin
         h_cnt <= '0;
         if (v_cnt == V_MAX)
            v_cnt <= '0;
         else
            v_cnt <= v_cnt + 11'd1;
      end else begin
         h_cnt <= h_cnt + 11'd1;
      end
   end

   assign de          = (h_cnt < H_VIS_LIM) && (v_cnt < V_VIS_LIM);
   assign hs          = (h_cnt >= HS_START) && (h_cnt <= HS_END);
   assign vs          = (v_cnt >= VS_START) && (v_cnt <= VS_END);
   assign frame_first = (h_cnt == 11'd0) && (v_cnt == 11'd0);

endmodule

// File: rtl/vga_scan.sv
// VGA scan-out: framebuffer address generation, sync delay line matched to
// memory read latency, and registered colour/sync pins.
module vga_scan
   import vga_pkg::*;
#(
   parameter int H_VIS    = H_VIS_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_VIS    = V_VIS_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter int SCALE_SH = SCALE_SH_DEF,
   parameter int FB_W     = FB_W_DEF,
   parameter int RD_LAT   = RD_LAT_DEF
)(
   input  logic        clk,
   input  logic        rst,
   output logic [14:0] screen_addr,
   input  logic [11:0] screen_data,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_start
);

   localparam int          DLY_N     = RD_LAT + 1;
   localparam logic [10:0] H_LAST    = 11'(H_VIS - 1);
   localparam logic [10:0] H_MAX     = 11'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] V_MAX     = 11'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] V_VIS_LIM = 11'(V_VIS);
   localparam logic [10:0] V_MASK    = 11'((1 << SCALE_SH) - 1);

   logic [10:0]         h_cnt;
   logic [10:0]         v_cnt;
   logic [14:0]         row_base;
   sync_t               raw;
   sync_t [DLY_N-1:0]   dly;

   vga_timing #(
      .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
      .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
   ) u_timing (
      .clk         (clk),
      .rst         (rst),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .de          (raw.de),
      .hs          (raw.hs),
      .vs          (raw.vs),
      .frame_first (raw.fs)
   );

   // Row base steps one buffer row after the last screen line sharing it,
   // so the next visible line starts on the new row without a multiply.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_base <= '0;
      end else if (h_cnt == H_MAX && v_cnt == V_MAX) begin
         row_base <= '0;
      end else if (h_cnt == H_LAST && v_cnt < V_VIS_LIM && (v_cnt & V_MASK) == V_MASK) begin
         row_base <= row_base + 15'(FB_W);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         screen_addr <= '0;
      else if (raw.de)
         screen_addr <= row_base + 15'(h_cnt >> SCALE_SH);
      else
         screen_addr <= '0;
   end

   // Sync/enable travel alongside the address and the memory read
   always_ff @(posedge clk) begin
      if (rst) begin
         dly <= '0;
      end else begin
         dly[0] <= raw;
         for (int i = 1; i < DLY_N; i++)
            dly[i] <= dly[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vga_hs      <= 1'b0;
         vga_vs      <= 1'b0;
         frame_start <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
      end else begin
         vga_hs      <= dly[DLY_N-1].hs;
         vga_vs      <= dly[DLY_N-1].vs;
         frame_start <= dly[DLY_N-1].fs;
         if (dly[DLY_N-1].de) begin
            vga_r <= screen_data[R_HI:R_LO];
            vga_g <= screen_data[G_HI:G_LO];
            vga_b <= screen_data[B_HI:B_LO];
         end else begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan on a shrunken timing set, two instances (RD_LAT 1 and 2)
// checked against a multiply-based reference model through scoreboard queues.
module tb_vga_scan;

   localparam int HV = 64, HF = 4, HS = 8, HB = 4;
   localparam int VV = 32, VF = 2, VS = 3, VB = 3;
   localparam int SH = 2, FBW = 200;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int P1 = 3, P2 = 4;

   typedef struct packed {
      logic        fs;
      logic        hs;
      logic        vs;
      logic [3:0]  r;
      logic [3:0]  g;
      logic [3:0]  b;
      logic [14:0] addr;
   } exp_t;

   typedef struct {
      int h;
      int v;
      int addr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [14:0] addr1, addr2;
   logic [11:0] data1, data2;
   logic [11:0] mem1, mem2a, mem2b;
   logic        hs1, vs1, fs1, hs2, vs2, fs2;
   logic [3:0]  r1, g1, b1, r2, g2, b2;
   logic [14:0] pins1, pins2;

   int n_cmp = 0;
   int n_bad = 0;
   int hc = 0;
   int vc = 0;
   bit sb_on = 1'b0;
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   vga_scan #(
      .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SCALE_SH(SH), .FB_W(FBW), .RD_LAT(1)
   ) dut1 (
      .clk(clk), .rst(rst), .screen_addr(addr1), .screen_data(data1),
      .vga_hs(hs1), .vga_vs(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
      .frame_start(fs1)
   );

   vga_scan #(
      .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SCALE_SH(SH), .FB_W(FBW), .RD_LAT(2)
   ) dut2 (
      .clk(clk), .rst(rst), .screen_addr(addr2), .screen_data(data2),
      .vga_hs(hs2), .vga_vs(vs2), .vga_r(r2), .vga_g(g2), .vga_b(b2),
      .frame_start(fs2)
   );

   // Framebuffer models: pixel value is the low 12 address bits
   initial begin
      mem1  = '0;
      mem2a = '0;
      mem2b = '0;
   end
   always @(posedge clk) begin
      mem1  <= addr1[11:0];
      mem2a <= addr2[11:0];
      mem2b <= mem2a;
   end
   assign data1 = mem1;
   assign data2 = mem2b;

   assign pins1 = {fs1, hs1, vs1, r1, g1, b1};
   assign pins2 = {fs2, hs2, vs2, r2, g2, b2};

   function automatic exp_t model(int h, int v);
      exp_t e;
      logic de;
      logic [14:0] a;
      e  = '0;
      de = (h < HV) && (v < VV);
      a  = de ? 15'((v >> SH) * FBW + (h >> SH)) : 15'd0;
      e.addr = a;
      e.fs   = (h == 0) && (v == 0);
      e.hs   = (h >= HV + HF) && (h < HV + HF + HS);
      e.vs   = (v >= VV + VF) && (v < VV + VF + VS);
      if (de) begin
         e.r = a[11:8];
         e.g = a[7:4];
         e.b = a[3:0];
      end
      return e;
   endfunction

   function automatic logic [14:0] pin_part(exp_t e);
      return {e.fs, e.hs, e.vs, e.r, e.g, e.b};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic r);
      @(negedge clk);
      rst = r;
   endtask

   task automatic waitFor(input int h, input int v, output bit ok);
      int n;
      n  = 0;
      ok = 1'b1;
      while (!(hc == h && vc == v)) begin
         if (n >= 5000) begin
            ok = 1'b0;
            break;
         end
         @(posedge clk);
         #2;
         n++;
      end
   endtask

   // Reference counters advance each edge; pins lag them by P, the address by one
   always @(posedge clk) begin
      logic rst_at_edge;
      exp_t e;
      rst_at_edge = rst;
      #1;
      if (rst_at_edge) begin
         hc = 0;
         vc = 0;
         q1.delete();
         q2.delete();
         for (int i = 0; i < P1; i++) q1.push_back('0);
         for (int i = 0; i < P2; i++) q2.push_back('0);
         sb_on = 1'b1;
      end else if (sb_on) begin
         if (hc == HT - 1) begin
            hc = 0;
            vc = (vc == VT - 1) ? 0 : vc + 1;
         end else begin
            hc++;
         end
      end
      if (sb_on) begin
         q1.push_back(model(hc, vc));
         q2.push_back(model(hc, vc));
         e = q1[q1.size() - 2];
         checkOutput("addr1", 64'(addr1), 64'(e.addr));
         e = q2[q2.size() - 2];
         checkOutput("addr2", 64'(addr2), 64'(e.addr));
         e = q1.pop_front();
         checkOutput("pins1", 64'(pins1), 64'(pin_part(e)));
         e = q2.pop_front();
         checkOutput("pins2", 64'(pins2), 64'(pin_part(e)));
      end
   end

   initial begin
      vec_t vecs[12];
      int   line0[8];
      bit   ok;
      int   hs_hi, vs_hi, hs_rise, vs_rise, fs_cnt, last_hs, last_vs;
      logic hs_prev, vs_prev;

      vecs[0]  = '{12, 0, 3};
      vecs[1]  = '{63, 0, 15};
      vecs[2]  = '{64, 0, 0};
      vecs[3]  = '{79, 0, 0};
      vecs[4]  = '{0, 4, 200};
      vecs[5]  = '{5, 7, 201};
      vecs[6]  = '{0, 8, 400};
      vecs[7]  = '{63, 31, 1415};
      vecs[8]  = '{64, 31, 0};
      vecs[9]  = '{0, 32, 0};
      vecs[10] = '{40, 36, 0};
      vecs[11] = '{79, 39, 0};
      line0 = '{0, 0, 0, 0, 1, 1, 1, 1};

      rst = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      checkOutput("reset_state", {2'b0, pins1, addr1, pins2, addr2}, 64'd0);

      // First frame after release: frame_start latency and line-0 colours
      applyStimulus(1'b0);
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #2;
         checkOutput("fs_latency1", 64'(fs1), 64'(k == P1));
         checkOutput("fs_latency2", 64'(fs2), 64'(k == P2));
         if (k >= P1) checkOutput("line0_b1", 64'(b1), 64'(line0[k - P1]));
         if (k >= P2) checkOutput("line0_b2", 64'(b2), 64'(line0[k - P2]));
      end

      for (int i = 0; i < 12; i++) begin
         waitFor(vecs[i].h, vecs[i].v, ok);
         if (!ok) begin
            checkOutput("wait_timeout", 64'd1, 64'd0);
         end else begin
            @(posedge clk);
            #2;
            checkOutput("vec_addr1", 64'(addr1), 64'(vecs[i].addr));
            checkOutput("vec_addr2", 64'(addr2), 64'(vecs[i].addr));
         end
      end

      // Two whole frames of sync statistics on the RD_LAT=1 instance
      hs_hi = 0; vs_hi = 0; hs_rise = 0; vs_rise = 0; fs_cnt = 0;
      last_hs = -1; last_vs = -1;
      hs_prev = hs1;
      vs_prev = vs1;
      for (int c = 0; c < 2 * HT * VT; c++) begin
         @(posedge clk);
         #2;
         if (hs1) hs_hi++;
         if (vs1) vs_hi++;
         if (fs1) fs_cnt++;
         if (hs1 && !hs_prev) begin
            hs_rise++;
            if (last_hs >= 0) checkOutput("hs_period", 64'(c - last_hs), 64'(HT));
            last_hs = c;
         end
         if (vs1 && !vs_prev) begin
            vs_rise++;
            if (last_vs >= 0) checkOutput("vs_period", 64'(c - last_vs), 64'(HT * VT));
            last_vs = c;
         end
         hs_prev = hs1;
         vs_prev = vs1;
      end
      checkOutput("hs_rises", 64'(hs_rise), 64'(2 * VT));
      checkOutput("hs_high", 64'(hs_hi), 64'(2 * VT * HS));
      checkOutput("vs_rises", 64'(vs_rise), 64'd2);
      checkOutput("vs_high", 64'(vs_hi), 64'(2 * VS * HT));
      checkOutput("fs_count", 64'(fs_cnt), 64'd2);

      // Mid-frame reset aborts the frame and restarts it cleanly
      waitFor(10, 16, ok);
      if (!ok) checkOutput("wait_timeout", 64'd1, 64'd0);
      applyStimulus(1'b1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #2;
         checkOutput("reset_mid", {2'b0, pins1, addr1, pins2, addr2}, 64'd0);
      end
      applyStimulus(1'b0);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #2;
         checkOutput("fs_restart1", 64'(fs1), 64'(k == P1));
         checkOutput("fs_restart2", 64'(fs2), 64'(k == P2));
      end

      repeat (200) @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
